// File: rtl/iob_tdp_rom_arb.sv
// iob_tdp_rom_arb: round-robin arbiter sharing one true-dual-port ROM
// between N_REQ read requesters. Up to two grants per cycle (port A, port B).
// ROM read data comes back one cycle later on the owning requester's slice.
module iob_tdp_rom_arb #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          resp_valid,
  output logic [N_REQ*DATA_W-1:0]   resp_data,
  output logic [ADDR_W-1:0]         rom_addr_a,
  output logic                      rom_r_en_a,
  input  logic [DATA_W-1:0]         rom_q_a,
  output logic [ADDR_W-1:0]         rom_addr_b,
  output logic                      rom_r_en_b,
  input  logic [DATA_W-1:0]         rom_q_b
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W:0]   N_LIM = (IDX_W+1)'(N_REQ);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_REQ - 1);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_nxt;
  logic [IDX_W-1:0] gnt_a_idx;
  logic [IDX_W-1:0] gnt_b_idx;
  logic             gnt_a_vld;
  logic             gnt_b_vld;
  logic [IDX_W-1:0] own_a;
  logic [IDX_W-1:0] own_b;
  logic             vld_a;
  logic             vld_b;

  // Port A: first valid requester scanning from ptr, wrapping mod N_REQ
  always_comb begin : grant_a
    logic [IDX_W:0] s;
    gnt_a_vld = 1'b0;
    gnt_a_idx = '0;
    s         = '0;
    for (int o = 0; o < N_REQ; o++) begin
      s = {1'b0, ptr} + (IDX_W+1)'(o);
      if (s >= N_LIM) s = s - N_LIM;
      if (!gnt_a_vld && req_valid[s[IDX_W-1:0]]) begin
        gnt_a_vld = 1'b1;
        gnt_a_idx = s[IDX_W-1:0];
      end
    end
  end

  // Port B: first valid requester after the port A winner, never the same one
  always_comb begin : grant_b
    logic [IDX_W:0] s;
    gnt_b_vld = 1'b0;
    gnt_b_idx = '0;
    s         = '0;
    for (int o = 1; o < N_REQ; o++) begin
      s = {1'b0, gnt_a_idx} + (IDX_W+1)'(o);
      if (s >= N_LIM) s = s - N_LIM;
      if (gnt_a_vld && !gnt_b_vld && req_valid[s[IDX_W-1:0]]) begin
        gnt_b_vld = 1'b1;
        gnt_b_idx = s[IDX_W-1:0];
      end
    end
  end

  // Handshake, ROM pin drive and next round-robin pointer
  always_comb begin
    req_ready = '0;
    if (gnt_a_vld) req_ready[gnt_a_idx] = 1'b1;
    if (gnt_b_vld) req_ready[gnt_b_idx] = 1'b1;

    rom_r_en_a = gnt_a_vld;
    rom_r_en_b = gnt_b_vld;
    rom_addr_a = gnt_a_vld ? req_addr[int'(gnt_a_idx)*ADDR_W +: ADDR_W] : '0;
    rom_addr_b = gnt_b_vld ? req_addr[int'(gnt_b_idx)*ADDR_W +: ADDR_W] : '0;

    ptr_nxt = ptr;
    if (gnt_b_vld)
      ptr_nxt = (gnt_b_idx == LAST) ? '0 : gnt_b_idx + 1'b1;
    else if (gnt_a_vld)
      ptr_nxt = (gnt_a_idx == LAST) ? '0 : gnt_a_idx + 1'b1;
  end

  // Pointer and port-ownership tags; reset drops any in-flight response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      own_a <= '0;
      own_b <= '0;
      vld_a <= 1'b0;
      vld_b <= 1'b0;
    end else begin
      ptr   <= ptr_nxt;
      own_a <= gnt_a_idx;
      own_b <= gnt_b_idx;
      vld_a <= gnt_a_vld;
      vld_b <= gnt_b_vld;
    end
  end

  // Route registered ROM data to the owning requester; idle slices read 0
  always_comb begin
    resp_valid = '0;
    resp_data  = '0;
    if (vld_a) begin
      resp_valid[own_a] = 1'b1;
      resp_data[int'(own_a)*DATA_W +: DATA_W] = rom_q_a;
    end
    if (vld_b) begin
      resp_valid[own_b] = 1'b1;
      resp_data[int'(own_b)*DATA_W +: DATA_W] = rom_q_b;
    end
  end

endmodule

// File: tb/tb_iob_tdp_rom_arb.sv
// Directed bench for iob_tdp_rom_arb with N_REQ=4 and a ROM model whose
// word[i] = 0x1000 + i, registered on each port.
module tb_iob_tdp_rom_arb;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 11;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [N_REQ-1:0]        req_valid = '0;
  logic [N_REQ*ADDR_W-1:0] req_addr = '0;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        resp_valid;
  logic [N_REQ*DATA_W-1:0] resp_data;
  logic [ADDR_W-1:0]       rom_addr_a;
  logic                    rom_r_en_a;
  logic [DATA_W-1:0]       rom_q_a = '0;
  logic [ADDR_W-1:0]       rom_addr_b;
  logic                    rom_r_en_b;
  logic [DATA_W-1:0]       rom_q_b = '0;

  int vectors = 0;
  int miscompares = 0;

  iob_tdp_rom_arb #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .rom_addr_a(rom_addr_a), .rom_r_en_a(rom_r_en_a), .rom_q_a(rom_q_a),
    .rom_addr_b(rom_addr_b), .rom_r_en_b(rom_r_en_b), .rom_q_b(rom_q_b)
  );

  always #5 clk = ~clk;

  // ROM model: synchronous read, word[i] = 0x1000 + i
  always @(posedge clk) begin
    if (rom_r_en_a) rom_q_a <= 32'h1000 + 32'(rom_addr_a);
    if (rom_r_en_b) rom_q_b <= 32'h1000 + 32'(rom_addr_b);
  end

  function automatic logic [DATA_W-1:0] slice(input int i);
    return resp_data[i*DATA_W +: DATA_W];
  endfunction

  task automatic set_addr(input int i, input int a);
    req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    vectors++;
    if (resp_valid !== 4'b0000) begin miscompares++; $display("FAIL reset_resp_valid got %b exp 0000", resp_valid); end
    vectors++;
    if (resp_data !== '0) begin miscompares++; $display("FAIL reset_resp_data got %h exp 0", resp_data); end
    vectors++;
    if ({rom_r_en_a, rom_r_en_b, req_ready} !== 6'b0) begin miscompares++; $display("FAIL reset_grants got %b exp 000000", {rom_r_en_a, rom_r_en_b, req_ready}); end
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    // probe ptr=0 without letting a grant be taken at an edge
    req_valid = 4'b1111;
    #1;
    vectors++;
    if (req_ready !== 4'b0011) begin miscompares++; $display("FAIL reset_first_grant got %b exp 0011", req_ready); end
    req_valid = 4'b0000;
  endtask

  task automatic test_single();
    set_addr(2, 5);
    req_valid = 4'b0100;
    #1;
    vectors++;
    if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL single_ready got %b exp 0100", req_ready); end
    vectors++;
    if ({rom_r_en_a, rom_addr_a, rom_r_en_b} !== {1'b1, 11'd5, 1'b0}) begin miscompares++; $display("FAIL single_rom got en_a=%b addr_a=%0d en_b=%b exp 1 5 0", rom_r_en_a, rom_addr_a, rom_r_en_b); end
    next_cycle();
    req_valid = 4'b0000;
    vectors++;
    if (resp_valid !== 4'b0100) begin miscompares++; $display("FAIL single_resp_valid got %b exp 0100", resp_valid); end
    vectors++;
    if (resp_data !== {32'h0, 32'h1005, 32'h0, 32'h0}) begin miscompares++; $display("FAIL single_resp_data got %h exp slice2=00001005 others 0", resp_data); end
    next_cycle();
    vectors++;
    if (resp_valid !== 4'b0000) begin miscompares++; $display("FAIL single_no_repeat got %b exp 0000", resp_valid); end
  endtask

  // ptr is 3 here after the single request to requester 2
  task automatic test_wrap();
    set_addr(3, 20);
    set_addr(0, 21);
    req_valid = 4'b1001;
    #1;
    vectors++;
    if (req_ready !== 4'b1001) begin miscompares++; $display("FAIL wrap_ready got %b exp 1001", req_ready); end
    vectors++;
    if ({rom_addr_a, rom_addr_b, rom_r_en_a, rom_r_en_b} !== {11'd20, 11'd21, 2'b11}) begin miscompares++; $display("FAIL wrap_rom got a=%0d b=%0d en=%b%b exp 20 21 11", rom_addr_a, rom_addr_b, rom_r_en_a, rom_r_en_b); end
    next_cycle();
    req_valid = 4'b0000;
    vectors++;
    if (resp_valid !== 4'b1001) begin miscompares++; $display("FAIL wrap_resp_valid got %b exp 1001", resp_valid); end
    vectors++;
    if (slice(3) !== 32'h1014 || slice(0) !== 32'h1015) begin miscompares++; $display("FAIL wrap_resp_data got s3=%h s0=%h exp 1014 1015", slice(3), slice(0)); end
    req_valid = 4'b1111;
    #1;
    vectors++;
    if (req_ready !== 4'b0110) begin miscompares++; $display("FAIL wrap_next_ptr got %b exp 0110", req_ready); end
    req_valid = 4'b0000;
    next_cycle();
  endtask

  // ptr is 1 here: A goes to 1, B to 0, both reading address 7
  task automatic test_collision();
    set_addr(0, 7);
    set_addr(1, 7);
    req_valid = 4'b0011;
    #1;
    vectors++;
    if ({rom_addr_a, rom_addr_b, rom_r_en_a, rom_r_en_b} !== {11'd7, 11'd7, 2'b11}) begin miscompares++; $display("FAIL coll_rom got a=%0d b=%0d en=%b%b exp 7 7 11", rom_addr_a, rom_addr_b, rom_r_en_a, rom_r_en_b); end
    next_cycle();
    req_valid = 4'b0000;
    vectors++;
    if (resp_valid !== 4'b0011) begin miscompares++; $display("FAIL coll_resp_valid got %b exp 0011", resp_valid); end
    vectors++;
    if (resp_data !== {32'h0, 32'h0, 32'h1007, 32'h1007}) begin miscompares++; $display("FAIL coll_resp_data got %h exp slices0,1=00001007", resp_data); end
    next_cycle();
  endtask

  task automatic test_midreset();
    set_addr(1, 9);
    req_valid = 4'b0010;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL mrst_ready got %b exp 0010", req_ready); end
    next_cycle();
    req_valid = 4'b0000;
    vectors++;
    if (resp_valid !== 4'b0010 || slice(1) !== 32'h1009) begin miscompares++; $display("FAIL mrst_pre_resp got v=%b d=%h exp 0010 1009", resp_valid, slice(1)); end
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (resp_valid !== 4'b0000 || resp_data !== '0) begin miscompares++; $display("FAIL mrst_async_clear got v=%b d=%h exp 0000 0", resp_valid, resp_data); end
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    vectors++;
    if (resp_valid !== 4'b0000) begin miscompares++; $display("FAIL mrst_stale got %b exp 0000", resp_valid); end
    req_valid = 4'b1111;
    #1;
    vectors++;
    if (req_ready !== 4'b0011) begin miscompares++; $display("FAIL mrst_first_grant got %b exp 0011", req_ready); end
    req_valid = 4'b0000;
  endtask

  task automatic test_all_valid();
    logic [3:0] exp_rdy [3];
    logic [3:0] exp_rsp [4];
    exp_rdy = '{4'b0011, 4'b1100, 4'b0011};
    exp_rsp = '{4'b0000, 4'b0011, 4'b1100, 4'b0011};
    for (int i = 0; i < N_REQ; i++) set_addr(i, 10 + i);
    req_valid = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) req_valid = 4'b0000;
      #1;
      if (c < 3) begin
        vectors++;
        if (req_ready !== exp_rdy[c]) begin miscompares++; $display("FAIL all_ready c%0d got %b exp %b", c, req_ready, exp_rdy[c]); end
      end
      vectors++;
      if (resp_valid !== exp_rsp[c]) begin miscompares++; $display("FAIL all_resp_valid c%0d got %b exp %b", c, resp_valid, exp_rsp[c]); end
      for (int i = 0; i < N_REQ; i++) begin
        if (exp_rsp[c][i]) begin
          vectors++;
          if (slice(i) !== 32'h100A + 32'(i)) begin miscompares++; $display("FAIL all_resp_data c%0d s%0d got %h exp %h", c, i, slice(i), 32'h100A + 32'(i)); end
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 4; c++) begin
      if (c < 3) begin
        set_addr(2, 1 + c);
        req_valid = 4'b0100;
      end else begin
        req_valid = 4'b0000;
      end
      #1;
      if (c < 3) begin
        vectors++;
        if (req_ready !== 4'b0100 || rom_addr_a !== 11'(1 + c)) begin miscompares++; $display("FAIL b2b_grant c%0d got rdy=%b addr=%0d exp 0100 %0d", c, req_ready, rom_addr_a, 1 + c); end
      end
      if (c > 0) begin
        vectors++;
        if (resp_valid !== 4'b0100 || slice(2) !== 32'h1000 + 32'(c)) begin miscompares++; $display("FAIL b2b_resp c%0d got v=%b d=%h exp 0100 %h", c, resp_valid, slice(2), 32'h1000 + 32'(c)); end
      end
      next_cycle();
    end
    vectors++;
    if (resp_valid !== 4'b0000) begin miscompares++; $display("FAIL b2b_idle got %b exp 0000", resp_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_collision();
    test_midreset();
    test_all_valid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iob_tdp_rom_arb.md
Name: iob_tdp_rom_arb

Overview:
- Round-robin arbiter that shares one true-dual-port ROM between N_REQ independent read requesters.
- Each cycle it grants up to two requests, one on ROM port A and one on ROM port B, and drives the ROM's addr/r_en pins.
- It routes the ROM's registered output back to the owning requester one cycle later, with a per-requester valid pulse.
- Sits between CPU/DMA-style read masters and a synchronous-read dual-port ROM instance.

Parameters:
N_REQ, 4, number of requesters; legal range 2..16
DATA_W, 32, ROM word width
ADDR_W, 11, ROM address width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
req_valid  input  N_REQ  bit i: requester i has a read pending
req_addr  input  N_REQ*ADDR_W  requester i address at bits [i*ADDR_W +: ADDR_W]
req_ready  output  N_REQ  bit i: request i accepted this cycle (combinational)
resp_valid  output  N_REQ  bit i: one-cycle pulse, resp_data slice i valid
resp_data  output  N_REQ*DATA_W  slice i carries requester i read data
rom_addr_a  output  ADDR_W  ROM port A address
rom_r_en_a  output  1  ROM port A read enable
rom_q_a  input  DATA_W  ROM port A data, registered inside ROM
rom_addr_b  output  ADDR_W  ROM port B address
rom_r_en_b  output  1  ROM port B read enable
rom_q_b  input  DATA_W  ROM port B data

Behaviour:
- Clocking/reset: single clock clk; rst asynchronous, active-high.
- Reset values: ptr=0, resp_valid=0, port-ownership tags=0, tag-valid flags=0.
- Reset is asynchronous and mid-operation: in-flight responses are dropped and resp_valid clears immediately. No response may appear after rst deasserts for a pre-reset request.
- Handshake: a request is accepted in cycle T when req_valid[i] & req_ready[i].
  - req_ready depends combinationally on req_valid and the pointer only.
  - Requesters may change req_addr/req_valid freely when not accepted; there is no stickiness requirement.
- Grant A: first index j with req_valid[j], scanning ptr, ptr+1, ... mod N_REQ.
- Grant B: first index k != j with req_valid[k], scanning j+1, j+2, ... mod N_REQ.
- req_ready has at most two bits set, and never two bits for the same requester.
- Number of requesters valid:
  - 0 valid: no grants.
  - 1 valid: port A only.
  - 2 or more valid: both ports.
- ROM drive (combinational, cycle T):
  - rom_r_en_a = grant A exists; rom_addr_a = req_addr[j], else 0.
  - Port B likewise with k.
- Pointer: at the edge ending cycle T, ptr <= (last granted index + 1) mod N_REQ.
  - Last granted index is k if B granted, else j.
  - ptr is unchanged when there are no grants.
- Response latency: exactly 1 cycle.
  - At the edge ending T, register ownerA=j/validA and ownerB=k/validB.
  - In cycle T+1, resp_valid[j]=validA and resp_data slice j = rom_q_a; same for k with rom_q_b.
  - Slices of requesters without resp_valid output 0.
- Throughput: back-to-back acceptance every cycle is permitted, so a single requester alone can sustain 1 read/cycle.
- Fairness: with all N_REQ requesters continuously valid, every requester is granted at least once every ceil(N_REQ/2) cycles.
- Pointer wrap: when j or k = N_REQ-1, the next scan wraps to 0.
- Address collision: A and B may carry the same address. This is legal for ROM, and both requesters get identical data.
- No internal buffering: a requester must accept its response in the resp_valid cycle. There is no backpressure on responses.

Test Plan:
- ROM init word[i]=0x1000+i, N_REQ=4. After reset, all outputs 0, and ptr=0 is observable by the first grant going to req 0.
- Only req 2 valid, addr 5, for one cycle → req_ready=0b0100, rom_r_en_a=1, rom_addr_a=5, rom_r_en_b=0. Next cycle resp_valid=0b0100, data slice 2 = 0x1005.
- All 4 valid continuously, addr_i = 10+i:
  - cycle 0 grants A=0, B=1;
  - cycle 1 grants A=2, B=3;
  - cycle 2 grants A=0, B=1.
  - Each response is 0x100A+i one cycle after its grant.
- req 3 and req 0 valid with ptr=3 → A=3, B=0 (wrap). Next ptr=1. Responses go to the correct slices.
- req 1 accepted at T, rst pulsed asynchronously mid-cycle T+1 → resp_valid drops to 0 immediately. After release, no stale pulse appears and the first grant goes to req 0.
- req 0 and req 1 both with addr 7 → both ports read 7. Both resp slices = 0x1007 in the same cycle.
